peri_sample_fifo: RTL

- Wishbone B4 peripheral that buffers 8-bit PCM/density samples from the PDM microphone front-end.
- Sits directly downstream of the microphone block: takes its 8-bit sample word and one-cycle sample strobe.
- CPU drains the samples through a 2-register wishbone window.
- Raises an interrupt at a programmable fill level, so the CPU services bursts instead of every sample.

---
 rtl/peri_sample_fifo.sv | 129 ++++++++++++
 1 files changed

// File: rtl/peri_sample_fifo.sv
// Wishbone sample FIFO for the PDM microphone front-end: buffers 8-bit samples,
// exposes DATA/THRESH and STATUS/CTRL registers, and raises a fill-level interrupt.
module peri_sample_fifo #(
  parameter int Depth  = 16,
  parameter int LevelW = $clog2(Depth) + 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] sample_i,
  input  logic       sample_valid_i,
  input  logic       wb_we_i,
  input  logic       wb_adr_i,
  input  logic [7:0] wb_dat_i,
  input  logic       wb_stb_i,
  output logic [7:0] wb_dat_o,
  output logic       wb_ack_o,
  output logic       irq_o
);

  localparam int PtrW = LevelW - 1;

  logic [7:0]        mem [Depth];
  logic [PtrW-1:0]   wr_ptr, rd_ptr;
  logic [LevelW-1:0] level, level_next;
  logic [LevelW-1:0] threshold, thresh_next;
  logic              overflow, overflow_next;

  logic accept, rd_data, rd_status, wr_thresh, wr_ctrl;
  logic pop, push, flush, clr_ovf, ovf_set;
  logic full, empty;
  logic [4:0] level5;
  logic [7:0] status;

  assign full   = (level == LevelW'(Depth));
  assign empty  = (level == '0);
  assign level5 = 5'(level);
  assign status = {overflow, full, empty, level5};

  assign accept    = wb_stb_i && !wb_ack_o;
  assign rd_data   = accept && !wb_we_i && !wb_adr_i;
  assign rd_status = accept && !wb_we_i &&  wb_adr_i;
  assign wr_thresh = accept &&  wb_we_i && !wb_adr_i;
  assign wr_ctrl   = accept &&  wb_we_i &&  wb_adr_i;

  assign pop     = rd_data && !empty;
  assign flush   = wr_ctrl && wb_dat_i[0];
  assign clr_ovf = wr_ctrl && wb_dat_i[7];
  // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
  assign push    = sample_valid_i && !flush && (!full || pop);
  assign ovf_set = sample_valid_i && !flush && full && !pop;

  always_comb begin
    level_next = level;
    if (flush) begin
      level_next = '0;
    end else begin
      level_next = level + LevelW'(push) - LevelW'(pop);
    end
  end

  always_comb begin
    thresh_next = threshold;
    if (wr_thresh) begin
      if (wb_dat_i[4:0] > 5'(Depth)) begin
        thresh_next = LevelW'(Depth);
      end else begin
        thresh_next = LevelW'(wb_dat_i[4:0]);
      end
    end
  end

  always_comb begin
    overflow_next = overflow;
    if (clr_ovf) begin
      overflow_next = 1'b0;
    end
    if (ovf_set) begin
      overflow_next = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= sample_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      threshold <= '0;
      overflow  <= 1'b0;
      wb_ack_o  <= 1'b0;
      wb_dat_o  <= 8'h00;
      irq_o     <= 1'b0;
    end else begin
      wb_ack_o  <= accept;
      level     <= level_next;
      threshold <= thresh_next;
      overflow  <= overflow_next;
      irq_o     <= (thresh_next != '0) && (level_next >= thresh_next);

      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PtrW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PtrW'(1);
        end
      end

      if (accept) begin
        if (wb_we_i) begin
          wb_dat_o <= 8'h00;
        end else if (rd_status) begin
          wb_dat_o <= status;
        end else begin
          wb_dat_o <= empty ? 8'h00 : mem[rd_ptr];
        end
      end
    end
  end

endmodule
